// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite link bundle used on both the upstream and downstream sides of
// the arbiter. The "master" modport drives requests; "slave" answers them.
interface axi_lite_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) ();
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );

   modport slave (
      input  awaddr, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter. One transaction (read or write)
// is in flight at a time; grants rotate round-robin over
// {s0 write, s0 read, s1 write, s1 read}.
module axi_lite_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input logic                axi_aclk,
   input logic                axi_aresetn,
   axi_lite_arbiter_if.slave  s0_axi,
   axi_lite_arbiter_if.slave  s1_axi,
   axi_lite_arbiter_if.master m0_axi
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_FWD  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_WR_RET  = 3'd3,
      ST_RD_FWD  = 3'd4,
      ST_RD_DATA = 3'd5,
      ST_RD_RET  = 3'd6
   } state_t;

   state_t                  state_r, state_s;
   logic [1:0]              prio_r, prio_s;
   logic                    owner_r, owner_s;
   logic [3:0]              req_s;
   logic                    grant_vld_s;
   logic [1:0]              grant_idx_s;
   logic [1:0]              cand_s;
   logic                    owner_bready_s, owner_rready_s;
   logic                    cap_req_s, cap_b_s, cap_r_s;
   logic                    m0_awvalid_r, m0_awvalid_s;
   logic                    m0_wvalid_r, m0_wvalid_s;
   logic                    m0_arvalid_r, m0_arvalid_s;
   logic                    m0_bready_r, m0_bready_s;
   logic                    m0_rready_r, m0_rready_s;
   logic                    up_bvalid_r, up_bvalid_s;
   logic                    up_rvalid_r, up_rvalid_s;
   logic [ADDR_WIDTH-1:0]   awaddr_r, araddr_r;
   logic [DATA_WIDTH-1:0]   wdata_r, rdata_r;
   logic [STRB_WIDTH-1:0]   wstrb_r;
   logic [1:0]              bresp_r, rresp_r;

   // Request vector: a write is eligible only with both AW and W valid.
   always_comb begin
      req_s[0] = s0_axi.awvalid & s0_axi.wvalid;
      req_s[1] = s0_axi.arvalid;
      req_s[2] = s1_axi.awvalid & s1_axi.wvalid;
      req_s[3] = s1_axi.arvalid;
   end

   // Round-robin pick: scan from the farthest offset down so the requester
   // closest to prio_r is the last (winning) assignment.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = prio_r;
      cand_s      = prio_r + 2'd3;
      if (req_s[cand_s]) begin
         grant_vld_s = 1'b1;
         grant_idx_s = cand_s;
      end else begin
         grant_vld_s = grant_vld_s;
      end
      cand_s = prio_r + 2'd2;
      if (req_s[cand_s]) begin
         grant_vld_s = 1'b1;
         grant_idx_s = cand_s;
      end else begin
         grant_vld_s = grant_vld_s;
      end
      cand_s = prio_r + 2'd1;
      if (req_s[cand_s]) begin
         grant_vld_s = 1'b1;
         grant_idx_s = cand_s;
      end else begin
         grant_vld_s = grant_vld_s;
      end
      cand_s = prio_r;
      if (req_s[cand_s]) begin
         grant_vld_s = 1'b1;
         grant_idx_s = cand_s;
      end else begin
         grant_vld_s = grant_vld_s;
      end
      // Grants only from IDLE and never while reset is asserted.
      if ((state_r != ST_IDLE) || !axi_aresetn) begin
         grant_vld_s = 1'b0;
      end else begin
         grant_vld_s = grant_vld_s;
      end
   end

   // Upstream readies: only the winner sees them, only in the grant cycle.
   always_comb begin
      s0_axi.awready = 1'b0;
      s0_axi.wready  = 1'b0;
      s0_axi.arready = 1'b0;
      s1_axi.awready = 1'b0;
      s1_axi.wready  = 1'b0;
      s1_axi.arready = 1'b0;
      if (grant_vld_s) begin
         case (grant_idx_s)
            2'd0: begin
               s0_axi.awready = 1'b1;
               s0_axi.wready  = 1'b1;
            end
            2'd1: s0_axi.arready = 1'b1;
            2'd2: begin
               s1_axi.awready = 1'b1;
               s1_axi.wready  = 1'b1;
            end
            2'd3: s1_axi.arready = 1'b1;
            default: s0_axi.awready = 1'b0;
         endcase
      end else begin
         s0_axi.awready = 1'b0;
      end
   end

   // Next-state and next-output logic of the transaction FSM.
   always_comb begin
      state_s        = state_r;
      prio_s         = prio_r;
      owner_s        = owner_r;
      m0_awvalid_s   = m0_awvalid_r;
      m0_wvalid_s    = m0_wvalid_r;
      m0_arvalid_s   = m0_arvalid_r;
      m0_bready_s    = m0_bready_r;
      m0_rready_s    = m0_rready_r;
      up_bvalid_s    = up_bvalid_r;
      up_rvalid_s    = up_rvalid_r;
      cap_req_s      = 1'b0;
      cap_b_s        = 1'b0;
      cap_r_s        = 1'b0;
      owner_bready_s = owner_r ? s1_axi.bready : s0_axi.bready;
      owner_rready_s = owner_r ? s1_axi.rready : s0_axi.rready;
      case (state_r)
         ST_IDLE: begin
            if (grant_vld_s) begin
               cap_req_s = 1'b1;
               owner_s   = grant_idx_s[1];
               prio_s    = grant_idx_s + 2'd1;
               if (grant_idx_s[0]) begin
                  m0_arvalid_s = 1'b1;
                  state_s      = ST_RD_FWD;
               end else begin
                  m0_awvalid_s = 1'b1;
                  m0_wvalid_s  = 1'b1;
                  state_s      = ST_WR_FWD;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WR_FWD: begin
            // AW and W complete independently; move on once both are done.
            m0_awvalid_s = m0_awvalid_r & ~m0_axi.awready;
            m0_wvalid_s  = m0_wvalid_r & ~m0_axi.wready;
            if (!m0_awvalid_s && !m0_wvalid_s) begin
               m0_bready_s = 1'b1;
               state_s     = ST_WR_RESP;
            end else begin
               state_s = ST_WR_FWD;
            end
         end
         ST_WR_RESP: begin
            if (m0_axi.bvalid) begin
               cap_b_s     = 1'b1;
               m0_bready_s = 1'b0;
               up_bvalid_s = 1'b1;
               state_s     = ST_WR_RET;
            end else begin
               state_s = ST_WR_RESP;
            end
         end
         ST_WR_RET: begin
            if (owner_bready_s) begin
               up_bvalid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_WR_RET;
            end
         end
         ST_RD_FWD: begin
            if (m0_axi.arready) begin
               m0_arvalid_s = 1'b0;
               m0_rready_s  = 1'b1;
               state_s      = ST_RD_DATA;
            end else begin
               state_s = ST_RD_FWD;
            end
         end
         ST_RD_DATA: begin
            if (m0_axi.rvalid) begin
               cap_r_s     = 1'b1;
               m0_rready_s = 1'b0;
               up_rvalid_s = 1'b1;
               state_s     = ST_RD_RET;
            end else begin
               state_s = ST_RD_DATA;
            end
         end
         ST_RD_RET: begin
            if (owner_rready_s) begin
               up_rvalid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_RD_RET;
            end
         end
         default: begin
            state_s      = ST_IDLE;
            m0_awvalid_s = 1'b0;
            m0_wvalid_s  = 1'b0;
            m0_arvalid_s = 1'b0;
            m0_bready_s  = 1'b0;
            m0_rready_s  = 1'b0;
            up_bvalid_s  = 1'b0;
            up_rvalid_s  = 1'b0;
         end
      endcase
   end

   // Control registers: FSM state, priority pointer, owner, handshake flags.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_r      <= ST_IDLE;
         prio_r       <= 2'd0;
         owner_r      <= 1'b0;
         m0_awvalid_r <= 1'b0;
         m0_wvalid_r  <= 1'b0;
         m0_arvalid_r <= 1'b0;
         m0_bready_r  <= 1'b0;
         m0_rready_r  <= 1'b0;
         up_bvalid_r  <= 1'b0;
         up_rvalid_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         prio_r       <= prio_s;
         owner_r      <= owner_s;
         m0_awvalid_r <= m0_awvalid_s;
         m0_wvalid_r  <= m0_wvalid_s;
         m0_arvalid_r <= m0_arvalid_s;
         m0_bready_r  <= m0_bready_s;
         m0_rready_r  <= m0_rready_s;
         up_bvalid_r  <= up_bvalid_s;
         up_rvalid_r  <= up_rvalid_s;
      end
   end

   // Payload capture: request payload at grant, response payload on arrival.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         awaddr_r <= {ADDR_WIDTH{1'b0}};
         araddr_r <= {ADDR_WIDTH{1'b0}};
         wdata_r  <= {DATA_WIDTH{1'b0}};
         wstrb_r  <= {STRB_WIDTH{1'b0}};
         bresp_r  <= 2'b00;
         rdata_r  <= {DATA_WIDTH{1'b0}};
         rresp_r  <= 2'b00;
      end else begin
         if (cap_req_s) begin
            if (!grant_idx_s[0]) begin
               awaddr_r <= grant_idx_s[1] ? s1_axi.awaddr : s0_axi.awaddr;
               wdata_r  <= grant_idx_s[1] ? s1_axi.wdata  : s0_axi.wdata;
               wstrb_r  <= grant_idx_s[1] ? s1_axi.wstrb  : s0_axi.wstrb;
            end else begin
               araddr_r <= grant_idx_s[1] ? s1_axi.araddr : s0_axi.araddr;
            end
         end
         if (cap_b_s) begin
            bresp_r <= m0_axi.bresp;
         end
         if (cap_r_s) begin
            rdata_r <= m0_axi.rdata;
            rresp_r <= m0_axi.rresp;
         end
      end
   end

   // Drive the shared bus and route responses to the owner only.
   always_comb begin
      m0_axi.awaddr  = awaddr_r;
      m0_axi.awvalid = m0_awvalid_r;
      m0_axi.wdata   = wdata_r;
      m0_axi.wstrb   = wstrb_r;
      m0_axi.wvalid  = m0_wvalid_r;
      m0_axi.bready  = m0_bready_r;
      m0_axi.araddr  = araddr_r;
      m0_axi.arvalid = m0_arvalid_r;
      m0_axi.rready  = m0_rready_r;
      s0_axi.bvalid  = up_bvalid_r & ~owner_r;
      s1_axi.bvalid  = up_bvalid_r & owner_r;
      s0_axi.rvalid  = up_rvalid_r & ~owner_r;
      s1_axi.rvalid  = up_rvalid_r & owner_r;
      s0_axi.bresp   = (up_bvalid_r & ~owner_r) ? bresp_r : 2'b00;
      s1_axi.bresp   = (up_bvalid_r & owner_r)  ? bresp_r : 2'b00;
      s0_axi.rdata   = (up_rvalid_r & ~owner_r) ? rdata_r : {DATA_WIDTH{1'b0}};
      s1_axi.rdata   = (up_rvalid_r & owner_r)  ? rdata_r : {DATA_WIDTH{1'b0}};
      s0_axi.rresp   = (up_rvalid_r & ~owner_r) ? rresp_r : 2'b00;
      s1_axi.rresp   = (up_rvalid_r & owner_r)  ? rresp_r : 2'b00;
   end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: upstream request driver, downstream slave
// responder with programmable latencies, and a queue-based scoreboard
// monitor that checks every handshake the DUT presents.
module tb_axi_lite_arbiter;
   localparam int DW = 32;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s0_axi ();
   axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_axi ();
   axi_lite_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_axi ();

   axi_lite_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .s0_axi      (s0_axi),
      .s1_axi      (s1_axi),
      .m0_axi      (m0_axi)
   );

   typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
   typedef struct packed { logic m; logic [1:0] resp; } b_t;
   typedef struct packed { logic m; logic [31:0] data; logic [1:0] resp; } r_t;

   int         exp_grant[$];
   logic [7:0] exp_aw[$];
   w_t         exp_w[$];
   logic [7:0] exp_ar[$];
   b_t         exp_b[$];
   r_t         exp_r[$];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   // upstream stimulus controls
   int          wr_pend[2];
   int          rd_pend[2];
   logic [7:0]  wr_addr[2];
   logic [7:0]  rd_addr[2];
   logic [31:0] wr_data[2];
   logic [3:0]  wr_strb[2];
   logic        aw_only0 = 1'b0;
   int          r_lat_up = 0;
   // downstream responder controls
   int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
   logic [1:0]  cfg_bresp = 2'd0, cfg_rresp = 2'd0;
   logic [31:0] cfg_rdata = 32'd0;
   // per-test measurements
   int   grant_cyc, bready_cyc, sbv0_cyc, aw_hi, w_hi, ar_hi, rv1_hi;
   logic s0_aw_seen, s1_seen;
   logic prio_chk_pend = 1'b0;
   int   prio_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      tests_run++;
      tests_failed++;
      $display("FAIL %s: DUT presented an event, expected none", name);
   endtask

   task automatic clear_meas();
      grant_cyc = -100; bready_cyc = -100; sbv0_cyc = -100;
      aw_hi = 0; w_hi = 0; ar_hi = 0; rv1_hi = 0;
      s0_aw_seen = 1'b0; s1_seen = 1'b0;
   endtask

   // Upstream masters: hold requests while transactions are pending.
   initial begin
      logic hw0, hr0, hw1, hr1;
      int   rc0, rc1;
      rc0 = 0; rc1 = 0;
      for (int i = 0; i < 2; i++) begin
         wr_pend[i] = 0; rd_pend[i] = 0; wr_addr[i] = 8'd0; rd_addr[i] = 8'd0;
         wr_data[i] = 32'd0; wr_strb[i] = 4'd0;
      end
      s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0; s0_axi.arvalid = 1'b0;
      s0_axi.bready = 1'b0; s0_axi.rready = 1'b0;
      s0_axi.awaddr = 8'd0; s0_axi.wdata = 32'd0; s0_axi.wstrb = 4'd0; s0_axi.araddr = 8'd0;
      s1_axi.awvalid = 1'b0; s1_axi.wvalid = 1'b0; s1_axi.arvalid = 1'b0;
      s1_axi.bready = 1'b0; s1_axi.rready = 1'b0;
      s1_axi.awaddr = 8'd0; s1_axi.wdata = 32'd0; s1_axi.wstrb = 4'd0; s1_axi.araddr = 8'd0;
      forever begin
         @(negedge clk);
         hw0 = s0_axi.awvalid & s0_axi.awready & s0_axi.wvalid & s0_axi.wready;
         hr0 = s0_axi.arvalid & s0_axi.arready;
         hw1 = s1_axi.awvalid & s1_axi.awready & s1_axi.wvalid & s1_axi.wready;
         hr1 = s1_axi.arvalid & s1_axi.arready;
         @(posedge clk);
         #1;
         if (hw0 && wr_pend[0] > 0) wr_pend[0]--;
         if (hr0 && rd_pend[0] > 0) rd_pend[0]--;
         if (hw1 && wr_pend[1] > 0) wr_pend[1]--;
         if (hr1 && rd_pend[1] > 0) rd_pend[1]--;
         s0_axi.awvalid = (wr_pend[0] > 0) | aw_only0;
         s0_axi.wvalid  = (wr_pend[0] > 0);
         s0_axi.awaddr  = wr_addr[0]; s0_axi.wdata = wr_data[0]; s0_axi.wstrb = wr_strb[0];
         s0_axi.arvalid = (rd_pend[0] > 0); s0_axi.araddr = rd_addr[0];
         s1_axi.awvalid = (wr_pend[1] > 0);
         s1_axi.wvalid  = (wr_pend[1] > 0);
         s1_axi.awaddr  = wr_addr[1]; s1_axi.wdata = wr_data[1]; s1_axi.wstrb = wr_strb[1];
         s1_axi.arvalid = (rd_pend[1] > 0); s1_axi.araddr = rd_addr[1];
         s0_axi.bready = s0_axi.bvalid;
         s1_axi.bready = s1_axi.bvalid;
         s0_axi.rready = s0_axi.rvalid && (rc0 >= r_lat_up);
         s1_axi.rready = s1_axi.rvalid && (rc1 >= r_lat_up);
         rc0 = s0_axi.rvalid ? rc0 + 1 : 0;
         rc1 = s1_axi.rvalid ? rc1 + 1 : 0;
      end
   end

   // Downstream slave: readies/valids after a programmable number of cycles.
   initial begin
      int ac, wc, arc, bc, rc;
      ac = 0; wc = 0; arc = 0; bc = 0; rc = 0;
      m0_axi.awready = 1'b0; m0_axi.wready = 1'b0; m0_axi.arready = 1'b0;
      m0_axi.bvalid = 1'b0; m0_axi.bresp = 2'd0;
      m0_axi.rvalid = 1'b0; m0_axi.rdata = 32'd0; m0_axi.rresp = 2'd0;
      forever begin
         @(posedge clk);
         #1;
         m0_axi.awready = m0_axi.awvalid && (ac >= aw_lat);
         m0_axi.wready  = m0_axi.wvalid && (wc >= w_lat);
         m0_axi.arready = m0_axi.arvalid && (arc >= ar_lat);
         m0_axi.bvalid  = m0_axi.bready && (bc >= b_lat);
         m0_axi.rvalid  = m0_axi.rready && (rc >= r_lat);
         m0_axi.bresp   = cfg_bresp;
         m0_axi.rdata   = cfg_rdata;
         m0_axi.rresp   = cfg_rresp;
         ac  = m0_axi.awvalid ? ac + 1 : 0;
         wc  = m0_axi.wvalid ? wc + 1 : 0;
         arc = m0_axi.arvalid ? arc + 1 : 0;
         bc  = m0_axi.bready ? bc + 1 : 0;
         rc  = m0_axi.rready ? rc + 1 : 0;
      end
   end

   // Scoreboard monitor: pops expected items as the DUT presents handshakes.
   initial begin
      int nrdy, idx;
      logic m;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prio_chk_pend) begin
               chk("prio_after_grant", dut.prio_r, prio_exp);
               prio_chk_pend = 1'b0;
            end
            if (m0_axi.awvalid) aw_hi++;
            if (m0_axi.wvalid) w_hi++;
            if (m0_axi.arvalid) ar_hi++;
            if (s1_axi.rvalid) rv1_hi++;
            if (s0_axi.awready) s0_aw_seen = 1'b1;
            if (s1_axi.awready | s1_axi.wready | s1_axi.arready | s1_axi.bvalid |
                s1_axi.rvalid | (|s1_axi.rdata) | (|s1_axi.bresp) | (|s1_axi.rresp))
               s1_seen = 1'b1;
            if (m0_axi.bready && bready_cyc < 0) bready_cyc = cyc;
            if (s0_axi.bvalid && sbv0_cyc < 0) sbv0_cyc = cyc;
            nrdy = int'(s0_axi.awready) + int'(s0_axi.arready) + int'(s1_axi.awready) + int'(s1_axi.arready);
            if (nrdy > 1) chk("single_grant", nrdy, 1);
            else if (nrdy == 1) begin
               idx = s0_axi.awready ? 0 : s0_axi.arready ? 1 : s1_axi.awready ? 2 : 3;
               grant_cyc = cyc;
               if (exp_grant.size() == 0) unexpected("grant");
               else begin
                  chk("grant_idx", idx, exp_grant[0]);
                  prio_exp = (exp_grant.pop_front() + 1) % 4;
                  prio_chk_pend = 1'b1;
               end
               if (idx == 0) chk("s0_wready_pair", s0_axi.wready, 1'b1);
               if (idx == 2) chk("s1_wready_pair", s1_axi.wready, 1'b1);
            end
            if (m0_axi.awvalid && m0_axi.awready) begin
               if (exp_aw.size() == 0) unexpected("m0_aw");
               else chk("m0_awaddr", m0_axi.awaddr, exp_aw.pop_front());
            end
            if (m0_axi.wvalid && m0_axi.wready) begin
               if (exp_w.size() == 0) unexpected("m0_w");
               else begin
                  chk("m0_wdata", m0_axi.wdata, exp_w[0].data);
                  chk("m0_wstrb", m0_axi.wstrb, exp_w[0].strb);
                  void'(exp_w.pop_front());
               end
            end
            if (m0_axi.arvalid && m0_axi.arready) begin
               if (exp_ar.size() == 0) unexpected("m0_ar");
               else chk("m0_araddr", m0_axi.araddr, exp_ar.pop_front());
            end
            if (s0_axi.bvalid || s1_axi.bvalid) begin
               m = s1_axi.bvalid;
               if (exp_b.size() == 0) unexpected("up_b");
               else begin
                  chk("b_owner", {s1_axi.bvalid, s0_axi.bvalid}, exp_b[0].m ? 2'b10 : 2'b01);
                  chk("bresp", m ? s1_axi.bresp : s0_axi.bresp, exp_b[0].resp);
                  if ((s0_axi.bvalid & s0_axi.bready) | (s1_axi.bvalid & s1_axi.bready))
                     void'(exp_b.pop_front());
               end
            end
            if (s0_axi.rvalid || s1_axi.rvalid) begin
               m = s1_axi.rvalid;
               if (exp_r.size() == 0) unexpected("up_r");
               else begin
                  chk("r_owner", {s1_axi.rvalid, s0_axi.rvalid}, exp_r[0].m ? 2'b10 : 2'b01);
                  chk("rdata", m ? s1_axi.rdata : s0_axi.rdata, exp_r[0].data);
                  chk("rresp", m ? s1_axi.rresp : s0_axi.rresp, exp_r[0].resp);
                  if ((s0_axi.rvalid & s0_axi.rready) | (s1_axi.rvalid & s1_axi.rready))
                     void'(exp_r.pop_front());
               end
            end
         end
      end
   end

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_grant.size() + exp_aw.size() + exp_w.size() + exp_ar.size() +
              exp_b.size() + exp_r.size() + wr_pend[0] + wr_pend[1] +
              rd_pend[0] + rd_pend[1]) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, (n < 300), 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_meas();
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_m0_out", {m0_axi.awvalid, m0_axi.wvalid, m0_axi.arvalid, m0_axi.bready,
          m0_axi.rready, m0_axi.awaddr, m0_axi.araddr, m0_axi.wstrb}, 64'd0);
      chk("rst_m0_wdata", m0_axi.wdata, 64'd0);
      chk("rst_up_out", {s0_axi.awready, s0_axi.wready, s0_axi.arready, s0_axi.bvalid,
          s0_axi.rvalid, s0_axi.bresp, s0_axi.rresp, s1_axi.awready, s1_axi.wready,
          s1_axi.arready, s1_axi.bvalid, s1_axi.rvalid, s1_axi.bresp, s1_axi.rresp}, 64'd0);
      chk("rst_rdata", {s0_axi.rdata, s1_axi.rdata}, 64'd0);
      chk("rst_prio", dut.prio_r, 64'd0);
      chk("rst_state", dut.state_r, 64'd0);
      rst_n = 1'b1;

      // single write from s0, immediate downstream
      clear_meas();
      exp_grant.push_back(0); exp_aw.push_back(8'h10);
      exp_w.push_back('{data: 32'hDEADBEEF, strb: 4'hF});
      exp_b.push_back('{m: 1'b0, resp: 2'd0});
      wr_addr[0] = 8'h10; wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF; wr_pend[0] = 1;
      wait_done("single_write");
      chk("wr_bready_cycle", bready_cyc - grant_cyc, 2);
      chk("wr_sbvalid_cycle", sbv0_cyc - grant_cyc, 3);
      chk("wr_s1_quiet", s1_seen, 1'b0);

      // single read from s1 with downstream and upstream backpressure
      clear_meas();
      ar_lat = 3; r_lat_up = 2; cfg_rdata = 32'h12345678; cfg_rresp = 2'd2;
      exp_grant.push_back(3); exp_ar.push_back(8'h1C);
      exp_r.push_back('{m: 1'b1, data: 32'h12345678, resp: 2'd2});
      rd_addr[1] = 8'h1C; rd_pend[1] = 1;
      wait_done("read_bp");
      chk("rd_arvalid_cycles", ar_hi, 4);
      chk("rd_rvalid_cycles", rv1_hi, 3);
      ar_lat = 0; r_lat_up = 0;

      // round-robin with all four requesters
      pulse_reset();
      clear_meas();
      cfg_bresp = 2'd1; cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'd0;
      foreach (exp_grant[i]) exp_grant.delete(i);
      exp_grant = '{0, 1, 2, 3, 0};
      exp_aw = '{8'h20, 8'h30, 8'h20};
      exp_w.push_back('{data: 32'hA0A0A0A0, strb: 4'h3});
      exp_w.push_back('{data: 32'hB1B1B1B1, strb: 4'hC});
      exp_w.push_back('{data: 32'hA0A0A0A0, strb: 4'h3});
      exp_ar = '{8'h24, 8'h34};
      exp_b.push_back('{m: 1'b0, resp: 2'd1});
      exp_b.push_back('{m: 1'b1, resp: 2'd1});
      exp_b.push_back('{m: 1'b0, resp: 2'd1});
      exp_r.push_back('{m: 1'b0, data: 32'hCAFEF00D, resp: 2'd0});
      exp_r.push_back('{m: 1'b1, data: 32'hCAFEF00D, resp: 2'd0});
      wr_addr[0] = 8'h20; wr_data[0] = 32'hA0A0A0A0; wr_strb[0] = 4'h3; rd_addr[0] = 8'h24;
      wr_addr[1] = 8'h30; wr_data[1] = 32'hB1B1B1B1; wr_strb[1] = 4'hC; rd_addr[1] = 8'h34;
      wr_pend[0] = 2; rd_pend[0] = 1; wr_pend[1] = 1; rd_pend[1] = 1;
      wait_done("round_robin");

      // split AW/W channel completion
      clear_meas();
      w_lat = 3; cfg_bresp = 2'd0;
      exp_grant.push_back(0); exp_aw.push_back(8'h44);
      exp_w.push_back('{data: 32'h0BADC0DE, strb: 4'h9});
      exp_b.push_back('{m: 1'b0, resp: 2'd0});
      wr_addr[0] = 8'h44; wr_data[0] = 32'h0BADC0DE; wr_strb[0] = 4'h9; wr_pend[0] = 1;
      wait_done("split");
      chk("split_awvalid_cycles", aw_hi, 1);
      chk("split_wvalid_cycles", w_hi, 4);
      chk("split_bready_cycle", bready_cyc - grant_cyc, 5);
      w_lat = 0;

      // incomplete write request must not be granted
      clear_meas();
      cfg_rdata = 32'h87654321; cfg_rresp = 2'd0;
      exp_grant.push_back(3); exp_ar.push_back(8'h3C);
      exp_r.push_back('{m: 1'b1, data: 32'h87654321, resp: 2'd0});
      aw_only0 = 1'b1; rd_addr[1] = 8'h3C; rd_pend[1] = 1;
      wait_done("incomplete_wr");
      chk("incomplete_s0_awready", s0_aw_seen, 1'b0);
      aw_only0 = 1'b0;
      repeat (2) @(negedge clk);

      // asynchronous reset while waiting for read data
      clear_meas();
      r_lat = 1000;
      exp_grant.push_back(1); exp_ar.push_back(8'h40);
      rd_addr[0] = 8'h40; rd_pend[0] = 1;
      begin
         int n;
         n = 0;
         while (!m0_axi.rready && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("rst_mid_reached_rd_data", m0_axi.rready, 1'b1);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", {m0_axi.rready, m0_axi.bready, m0_axi.awvalid, m0_axi.wvalid,
          m0_axi.arvalid, s0_axi.bvalid, s0_axi.rvalid, s1_axi.bvalid, s1_axi.rvalid,
          s0_axi.arready, s1_axi.arready}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      r_lat = 0;
      chk("rst_mid_state", dut.state_r, 64'd0);
      chk("rst_mid_prio", dut.prio_r, 64'd0);
      clear_meas();
      exp_grant.push_back(2); exp_aw.push_back(8'h50);
      exp_w.push_back('{data: 32'h55AA55AA, strb: 4'h5});
      exp_b.push_back('{m: 1'b1, resp: 2'd0});
      wr_addr[1] = 8'h50; wr_data[1] = 32'h55AA55AA; wr_strb[1] = 4'h5; wr_pend[1] = 1;
      wait_done("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #400000;
      tests_run++;
      tests_failed++;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
